// File: rtl/cache_ctrl.sv
// Miss sequencer for a 2-way write-back data cache. Hits pass straight to the cache.
// A miss refills the line from memory, commits it in one cycle, then writes back any dirty victim.
module cache_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_rd_en,
   input  logic                  cpu_wr_en,
   input  logic [DATA_WIDTH-1:0] cpu_addr,
   input  logic                  hit,
   input  logic                  wb_valid,
   input  logic [DATA_WIDTH-1:0] wb_addr,
   input  logic [LINE_WIDTH-1:0] wb_data,
   output logic                  cache_rd_en,
   output logic                  cache_wr_en,
   output logic [LINE_WIDTH-1:0] fetch_data,
   output logic                  fetch_enable,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] hit_count,
   output logic [DATA_WIDTH-1:0] miss_count
);

   typedef enum logic [2:0] {
      IDLE,
      REFILL,
      COMMIT,
      POST,
      WRITEBACK
   } state_t;

   state_t                state_q, state_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [LINE_WIDTH-1:0] refill_q, refill_d;
   logic [DATA_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
   logic [DATA_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
   logic                  acc;
   logic                  unused_offset_bits;

   assign acc = cpu_rd_en | cpu_wr_en;
   // Memory works on whole lines, so the byte offset of either address never matters.
   assign unused_offset_bits = ^{cpu_addr[3:0], wb_addr[3:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         refill_q    <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         refill_q    <= refill_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      refill_d     = refill_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      cache_rd_en  = 1'b0;
      cache_wr_en  = 1'b0;
      fetch_enable = 1'b0;
      stall        = 1'b0;

      case (state_q)
         IDLE: begin
            if (acc) begin
               if (hit) begin
                  cache_rd_en = cpu_rd_en & ~cpu_wr_en;
                  cache_wr_en = cpu_wr_en;
                  hit_cnt_d   = hit_cnt_q + DATA_WIDTH'(1);
               end else begin
                  stall      = 1'b1;
                  miss_cnt_d = miss_cnt_q + DATA_WIDTH'(1);
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = {cpu_addr[DATA_WIDTH-1:4], 4'b0000};
                  state_d    = REFILL;
               end
            end
         end
         REFILL: begin
            stall = 1'b1;
            if (mem_req_q && mem_ready) begin
               refill_d  = mem_rdata;
               mem_req_d = 1'b0;
               state_d   = COMMIT;
            end
         end
         COMMIT: begin
            // The cache installs fetch_data and completes the pending access in this cycle.
            fetch_enable = 1'b1;
            cache_rd_en  = cpu_rd_en & ~cpu_wr_en;
            cache_wr_en  = cpu_wr_en;
            state_d      = POST;
         end
         POST: begin
            stall = acc;
            if (wb_valid) begin
               mem_addr_d  = {wb_addr[DATA_WIDTH-1:4], 4'b0000};
               mem_wdata_d = wb_data;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               state_d     = WRITEBACK;
            end else begin
               state_d = IDLE;
            end
         end
         WRITEBACK: begin
            stall = acc;
            if (mem_req_q && mem_ready) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign fetch_data = refill_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: a 2-way write-back cache model and a memory responder drive the controller,
// and a monitor checks memory transactions and cache accesses against queued expectations.
module tb_cache_ctrl;
   localparam int DW = 32;
   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          rst, cpu_rd_en, cpu_wr_en, hit, wb_valid, mem_ready;
   logic [DW-1:0] cpu_addr, wb_addr;
   logic [LW-1:0] wb_data, mem_rdata;
   logic          cache_rd_en, cache_wr_en, fetch_enable, stall, mem_req, mem_we;
   logic [LW-1:0] fetch_data, mem_wdata;
   logic [DW-1:0] mem_addr, hit_count, miss_count;

   always #5 clk = ~clk;

   cache_ctrl #(.DATA_WIDTH(DW), .LINE_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
      .hit(hit), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .cache_rd_en(cache_rd_en), .cache_wr_en(cache_wr_en), .fetch_data(fetch_data),
      .fetch_enable(fetch_enable), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   typedef struct packed {logic we; logic [31:0] addr; logic [127:0] data;} mem_txn_t;
   typedef struct packed {logic wr; logic miss; logic [127:0] line;} acc_txn_t;

   mem_txn_t mem_q[$];
   acc_txn_t acc_q[$];
   int errors = 0;
   int checks = 0;
   int exp_hits = 0;
   int exp_misses = 0;
   int lat_fixed = 0;

   // Reference memory (updated on eviction) and the memory the controller actually talks to.
   logic [127:0] model_mem [bit [31:0]];
   logic [127:0] phys_mem  [bit [31:0]];
   logic         c_valid [128][2];
   logic         c_dirty [128][2];
   logic [20:0]  c_tag   [128][2];
   logic [127:0] c_data  [128][2];
   int           c_lru   [128];

   function automatic logic [127:0] init_line(bit [31:0] a);
      return {a ^ 32'h1357_9BDF, a + 32'h0101_0101, ~a, a * 32'd3 + 32'd1};
   endfunction

   function automatic logic [127:0] model_rd(bit [31:0] a);
      if (model_mem.exists(a)) return model_mem[a];
      return init_line(a);
   endfunction

   function automatic logic [127:0] phys_rd(bit [31:0] a);
      if (phys_mem.exists(a)) return phys_mem[a];
      return init_line(a);
   endfunction

   task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Memory responder: answers after a random or fixed latency, pulses junk ready while idle.
   int rcnt = 0;
   int rlat = 1;
   always @(negedge clk) begin
      if (!mem_req) begin
         rcnt      = 0;
         mem_ready = ($urandom_range(0, 3) == 0);
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end else begin
         rcnt++;
         if (rcnt == 1) rlat = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 4);
         if (rcnt >= rlat) begin
            mem_ready = 1'b1;
            if (mem_we) phys_mem[mem_addr] = mem_wdata;
            else mem_rdata = phys_rd(mem_addr);
         end else begin
            mem_ready = 1'b0;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   // Monitor: pops an expectation whenever a memory handshake or a cache access happens.
   mem_txn_t mt;
   acc_txn_t at;
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (mem_req && mem_ready) begin
            if (mem_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_mem_req: actual we=%0d addr=%0h required none", mem_we, mem_addr);
            end else begin
               mt = mem_q.pop_front();
               cmp("mem_we", 128'(mem_we), 128'(mt.we));
               cmp("mem_addr", 128'(mem_addr), 128'(mt.addr));
               if (mt.we) cmp("mem_wdata", mem_wdata, mt.data);
            end
         end
         if (cache_rd_en || cache_wr_en) begin
            if (acc_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_cache_access: actual rd=%0d wr=%0d required none", cache_rd_en, cache_wr_en);
            end else begin
               at = acc_q.pop_front();
               cmp("cache_wr_en", 128'(cache_wr_en), 128'(at.wr));
               cmp("cache_rd_en", 128'(cache_rd_en), 128'(!at.wr));
               cmp("fetch_enable", 128'(fetch_enable), 128'(at.miss));
               if (at.miss) cmp("fetch_data", fetch_data, at.line);
            end
         end
      end
   end

   // Issue one CPU access at a negedge, hold it until it completes, update the cache model,
   // and present the dirty victim on the following (POST) cycle.
   task automatic do_access(input bit [31:0] a, input bit rd, input bit wr, output int sc);
      bit [6:0]   s = a[10:4];
      bit [20:0]  tg = a[31:11];
      bit [31:0]  la = {a[31:4], 4'b0000};
      bit [31:0]  va = '0;
      int         way = -1;
      int         v = 0;
      int         off = int'(a[3:2]) * 32;
      bit         wb_dirty = 1'b0;
      logic [127:0] line = '0;
      logic [127:0] vdata = '0;
      logic [31:0]  wdat;
      mem_txn_t   m;
      acc_txn_t   x;
      for (int w = 0; w < 2; w++) if (c_valid[s][w] && c_tag[s][w] == tg) way = w;
      if (way >= 0) begin
         exp_hits++;
         x.wr = wr; x.miss = 1'b0; x.line = '0;
         acc_q.push_back(x);
      end else begin
         exp_misses++;
         v = !c_valid[s][0] ? 0 : (!c_valid[s][1] ? 1 : c_lru[s]);
         line = model_rd(la);
         m.we = 1'b0; m.addr = la; m.data = '0;
         mem_q.push_back(m);
         if (c_valid[s][v] && c_dirty[s][v]) begin
            wb_dirty = 1'b1;
            va = {c_tag[s][v], s, 4'b0000};
            vdata = c_data[s][v];
            m.we = 1'b1; m.addr = va; m.data = vdata;
            mem_q.push_back(m);
         end
         x.wr = wr; x.miss = 1'b1; x.line = line;
         acc_q.push_back(x);
      end
      cpu_addr = a; cpu_rd_en = rd; cpu_wr_en = wr; hit = (way >= 0);
      sc = 0;
      #1;
      while (stall && sc < 200) begin
         sc++;
         @(negedge clk);
         wb_valid = 1'b0;
         #1;
      end
      if (stall) begin
         checks++; errors++;
         $display("FAIL access_timeout: actual stall=1 after %0d cycles required completion", sc);
      end
      @(posedge clk);
      wdat = $urandom;
      if (way >= 0) begin
         if (wr) begin
            c_dirty[s][way] = 1'b1;
            c_data[s][way][off +: 32] = wdat;
         end
         c_lru[s] = 1 - way;
      end else begin
         if (wb_dirty) model_mem[va] = vdata;
         c_valid[s][v] = 1'b1;
         c_tag[s][v]   = tg;
         c_dirty[s][v] = wr;
         c_data[s][v]  = line;
         if (wr) c_data[s][v][off +: 32] = wdat;
         c_lru[s] = 1 - v;
      end
      @(negedge clk);
      cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; hit = 1'b0;
      if (wb_dirty) begin
         wb_valid = 1'b1;
         wb_addr  = {va[31:4], 4'($urandom_range(0, 15))};
         wb_data  = vdata;
      end else begin
         wb_valid = 1'b0;
         wb_addr  = $urandom;
         wb_data  = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         wb_valid = ($urandom_range(0, 7) == 0);
         wb_addr  = $urandom;
         wb_data  = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   initial begin
      #1_000_000;
      checks++; errors++;
      $display("FAIL watchdog: actual time limit reached required completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int sc;
      bit [31:0] a;
      int r;
      for (int i = 0; i < 128; i++) begin
         c_lru[i] = 0;
         for (int w = 0; w < 2; w++) begin
            c_valid[i][w] = 1'b0; c_dirty[i][w] = 1'b0; c_tag[i][w] = '0; c_data[i][w] = '0;
         end
      end
      rst = 1'b1; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; hit = 1'b0;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      repeat (3) @(negedge clk);
      #2;
      cmp("reset_stall", 128'(stall), 128'(0));
      cmp("reset_mem_req", 128'(mem_req), 128'(0));
      cmp("reset_mem_addr", 128'(mem_addr), 128'(0));
      cmp("reset_fetch_data", fetch_data, 128'(0));
      cmp("reset_hit_count", 128'(hit_count), 128'(0));
      cmp("reset_miss_count", 128'(miss_count), 128'(0));
      rst = 1'b0;
      @(negedge clk);

      // Cold load, memory answers in the third refill cycle.
      lat_fixed = 3;
      model_mem[32'h100] = {96'h0123_4567_89AB_CDEF_0F1E_2D3C, 32'hDEAD_BEEF};
      phys_mem[32'h100]  = model_mem[32'h100];
      do_access(32'h0000_0100, 1'b1, 1'b0, sc);
      cmp("cold_miss_stall_cycles", 128'(sc), 128'(4));
      cmp("cold_miss_count", 128'(miss_count), 128'(1));
      idle(2);
      do_access(32'h0000_0104, 1'b1, 1'b0, sc);
      cmp("repeat_hit_stall_cycles", 128'(sc), 128'(0));
      cmp("repeat_hit_count", 128'(hit_count), 128'(1));

      // Dirty tag 0x5 in set 0x10 becomes the victim of a store miss; a load follows during writeback.
      lat_fixed = 0;
      idle(1);
      do_access(32'h0000_2900, 1'b1, 1'b0, sc);
      idle(1);
      do_access(32'h0000_2904, 1'b0, 1'b1, sc);
      do_access(32'h0000_0100, 1'b1, 1'b0, sc);
      lat_fixed = 2;
      do_access(32'h0000_3104, 1'b0, 1'b1, sc);
      do_access(32'h0000_0108, 1'b1, 1'b0, sc);
      cmp("load_during_writeback_stall", 128'(sc), 128'(3));
      do_access(32'h0000_010C, 1'b1, 1'b1, sc);
      lat_fixed = 0;

      for (int n = 0; n < 300; n++) begin
         a = {21'($urandom_range(0, 7)), 7'(7'h10 + $urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'b00};
         r = $urandom_range(0, 3);
         do_access(a, r != 0, r < 2, sc);
         idle($urandom_range(0, 2));
      end
      idle(10);
      cmp("final_hit_count", 128'(hit_count), 128'(exp_hits));
      cmp("final_miss_count", 128'(miss_count), 128'(exp_misses));
      cmp("mem_queue_drained", 128'(mem_q.size()), 128'(0));
      cmp("acc_queue_drained", 128'(acc_q.size()), 128'(0));

      // Reset in the second refill cycle abandons the miss.
      lat_fixed = 10;
      cpu_addr = 32'h0000_4000; cpu_rd_en = 1'b1; cpu_wr_en = 1'b0; hit = 1'b0; wb_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      cmp("refill_mem_req", 128'(mem_req), 128'(1));
      cmp("refill_miss_count", 128'(miss_count), 128'(exp_misses + 1));
      rst = 1'b1; cpu_rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #2;
      cmp("midrefill_reset_mem_req", 128'(mem_req), 128'(0));
      cmp("midrefill_reset_stall", 128'(stall), 128'(0));
      cmp("midrefill_reset_hit_count", 128'(hit_count), 128'(0));
      cmp("midrefill_reset_miss_count", 128'(miss_count), 128'(0));
      cmp("midrefill_reset_fetch_data", fetch_data, 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
